register_file_sb: RTL

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/register_file_sb_pkg.sv | 15 +
 rtl/register_file_sb_decoder_onehot.sv | 20 ++
 rtl/register_file_sb.sv | 105 ++++++++++
 3 files changed

// File: rtl/register_file_sb_pkg.sv
// Shared constants and the address-width helper for the scoreboarded register file.
package register_file_sb_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int NUM_REGS_DEF   = 32;

   // ceil(log2(n)) with a floor of 1 so a two-entry file still gets one index bit.
   function automatic int addr_width_f(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/register_file_sb_decoder_onehot.sv
// Index-to-one-hot decoder; indices at or above N decode to all-zero.
module decoder_onehot
   import register_file_sb_pkg::*;
#(
   parameter  int N = NUM_REGS_DEF,
   localparam int W = addr_width_f(N)
) (
   input  logic [W-1:0] idx_i,
   input  logic         en_i,
   output logic [N-1:0] sel_o
);

   always_comb begin
      sel_o = '0;
      for (int k = 0; k < N; k++) begin
         if (en_i && (idx_i == W'(k))) sel_o[k] = 1'b1;
      end
   end

endmodule

// File: rtl/register_file_sb.sv
// Register file with per-register pending (scoreboard) bits; register 0 is hardwired zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file_sb
   import register_file_sb_pkg::*;
#(
   parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter  int NUM_REGS   = NUM_REGS_DEF,
   localparam int ADDR_WIDTH = addr_width_f(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_WriteEnable,
   input  logic [ADDR_WIDTH-1:0] in_WriteRegister,
   input  logic [DATA_WIDTH-1:0] in_WriteData,
   input  logic [ADDR_WIDTH-1:0] in_ReadRegister1,
   input  logic [ADDR_WIDTH-1:0] in_ReadRegister2,
   output logic [DATA_WIDTH-1:0] o_ReadData1,
   output logic [DATA_WIDTH-1:0] o_ReadData2,
   input  logic                  in_Reserve,
   input  logic [ADDR_WIDTH-1:0] in_ReserveRegister,
   output logic                  o_Pending1,
   output logic                  o_Pending2,
   output logic [NUM_REGS-1:0]   o_WriteSelect
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1:1];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS-1:1];
   logic [NUM_REGS-1:0]   pending_q;
   logic [NUM_REGS-1:0]   pending_d;
   logic [NUM_REGS-1:0]   wsel;
   logic [NUM_REGS-1:0]   rsel;
   logic                  wr_en;
   logic                  rsv_en;

   // Gating by reset keeps strobes inert while the array is held clear.
   assign wr_en  = in_WriteEnable && reset && (in_WriteRegister != '0);
   assign rsv_en = in_Reserve && reset && (in_ReserveRegister != '0);

   decoder_onehot #(.N(NUM_REGS)) u_dec_wr (
      .idx_i (in_WriteRegister),
      .en_i  (wr_en),
      .sel_o (wsel)
   );

   decoder_onehot #(.N(NUM_REGS)) u_dec_rsv (
      .idx_i (in_ReserveRegister),
      .en_i  (rsv_en),
      .sel_o (rsel)
   );

   assign o_WriteSelect = wsel;

   // Reserve is OR-ed after the write clear, so a same-cycle reserve wins.
   assign pending_d = (pending_q & ~wsel) | rsel;

   always_comb begin
      regs_d = regs_q;
      for (int k = 1; k < NUM_REGS; k++) begin
         if (wsel[k]) regs_d[k] = in_WriteData;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 1; k < NUM_REGS; k++) regs_q[k] <= '0;
         pending_q <= '0;
      end else begin
         regs_q    <= regs_d;
         pending_q <= pending_d;
      end
   end

   logic [ADDR_WIDTH-1:0] raddr [2];
   logic [DATA_WIDTH-1:0] rdata [2];
   logic                  rpend [2];

   assign raddr[0] = in_ReadRegister1;
   assign raddr[1] = in_ReadRegister2;

   // Index 0 and out-of-range indices match no entry and fall through to zero.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = '0;
         rpend[p] = 1'b0;
         for (int k = 1; k < NUM_REGS; k++) begin
            if (raddr[p] == ADDR_WIDTH'(k)) begin
               rdata[p] = regs_q[k];
               rpend[p] = pending_q[k];
`ifdef REGFILE_BYPASS_EN
               if (wsel[k]) begin
                  rdata[p] = in_WriteData;
                  rpend[p] = rsel[k];
               end
`endif
            end
         end
      end
   end

   assign o_ReadData1 = rdata[0];
   assign o_ReadData2 = rdata[1];
   assign o_Pending1  = rpend[0];
   assign o_Pending2  = rpend[1];

endmodule
